trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
//
// Accepts one decoded trap instruction at a time (ECALL, EBREAK, MRET),
// latches its context, then walks a fixed sequence of CSR writes followed by
// a one-cycle fetch redirect. The pipeline is held by O_flush whenever the
// controller is not idle.
//
// Optional feature: define TRAP_EBREAK_HALT_EN to make EBREAK enter an
// absorbing HALT state (O_halt=1) instead of taking the ECALL-style trap with
// mcause=3. Without the macro O_halt is tied to 0.
//
// Ports:
//   I_clk, I_rst_n       clock, synchronous active-low reset
//   I_except_valid       trap instruction presented
//   O_except_ready       controller idle and able to accept
//   I_except[2:0]        one-hot kind: bit0 ECALL, bit1 EBREAK, bit2 MRET
//   I_pc                 PC of the trapping instruction
//   I_mtvec/I_mepc/I_mstatus  current CSR values
//   O_csr_we/O_csr_waddr/O_csr_wdata  single CSR write port
//   O_flush              pipeline flush/stall, high whenever not idle
//   O_redirect_valid/O_redirect_pc    one-cycle fetch redirect
//   O_halt               simulation halt
module trap_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic            I_except_valid,
  output logic            O_except_ready,
  input  logic [2:0]      I_except,
  input  logic [XLEN-1:0] I_pc,
  input  logic [XLEN-1:0] I_mtvec,
  input  logic [XLEN-1:0] I_mepc,
  input  logic [XLEN-1:0] I_mstatus,
  output logic            O_csr_we,
  output logic [11:0]     O_csr_waddr,
  output logic [XLEN-1:0] O_csr_wdata,
  output logic            O_flush,
  output logic            O_redirect_valid,
  output logic [XLEN-1:0] O_redirect_pc,
  output logic            O_halt
);

  localparam logic [2:0] st_idle       = 3'd0;
  localparam logic [2:0] st_wr_mepc    = 3'd1;
  localparam logic [2:0] st_wr_mcause  = 3'd2;
  localparam logic [2:0] st_wr_mstatus = 3'd3;
  localparam logic [2:0] st_redirect   = 3'd4;
  localparam logic [2:0] st_halt       = 3'd5;

  localparam logic [11:0] csr_mstatus = 12'h300;
  localparam logic [11:0] csr_mepc    = 12'h341;
  localparam logic [11:0] csr_mcause  = 12'h342;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            ebreak_q;
  logic [XLEN-1:0] mstatus_q;   // already-updated mstatus value to write
  logic [XLEN-1:0] target_q;    // redirect target resolved at accept

  logic            accept;
  logic            kind_ecall, kind_ebreak, kind_mret;
  logic [XLEN-1:0] mstatus_trap, mstatus_mret, mtvec_base;

  // Priority ECALL > EBREAK > MRET for multi-hot kinds.
  assign kind_ecall  = I_except[0];
  assign kind_ebreak = ~I_except[0] & I_except[1];
  assign kind_mret   = ~I_except[0] & ~I_except[1] & I_except[2];

  // A valid with no kind bit set is a no-op and is not accepted.
  assign accept = I_except_valid & (state_q == st_idle) & (|I_except);

  assign mtvec_base = I_mtvec & ~XLEN'(3);

  // mstatus bits: MIE=3, MPIE=7, MPP=12:11.
  always_comb begin
    mstatus_trap        = I_mstatus;
    mstatus_trap[7]     = I_mstatus[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_mret        = I_mstatus;
    mstatus_mret[3]     = I_mstatus[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: begin
        if (accept) begin
          if (kind_ecall) begin
            state_d = st_wr_mepc;
          end else if (kind_ebreak) begin
`ifdef TRAP_EBREAK_HALT_EN
            state_d = st_halt;
`else
            state_d = st_wr_mepc;
`endif
          end else begin
            state_d = st_wr_mstatus;
          end
        end
      end
      st_wr_mepc:    state_d = st_wr_mcause;
      st_wr_mcause:  state_d = st_wr_mstatus;
      st_wr_mstatus: state_d = st_redirect;
      st_redirect:   state_d = st_idle;
      st_halt:       state_d = st_halt;
      default:       state_d = st_idle;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q   <= st_idle;
      pc_q      <= '0;
      ebreak_q  <= 1'b0;
      mstatus_q <= '0;
      target_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q      <= I_pc;
        ebreak_q  <= kind_ebreak;
        mstatus_q <= kind_mret ? mstatus_mret : mstatus_trap;
        target_q  <= kind_mret ? I_mepc : mtvec_base;
      end
    end
  end

  // Outputs decode from state and latched context only.
  always_comb begin
    O_except_ready   = (state_q == st_idle);
    O_flush          = (state_q != st_idle);
    O_csr_we         = 1'b0;
    O_csr_waddr      = '0;
    O_csr_wdata      = '0;
    O_redirect_valid = 1'b0;
    O_redirect_pc    = '0;
    case (state_q)
      st_wr_mepc: begin
        O_csr_we    = 1'b1;
        O_csr_waddr = csr_mepc;
        O_csr_wdata = pc_q;
      end
      st_wr_mcause: begin
        O_csr_we    = 1'b1;
        O_csr_waddr = csr_mcause;
        O_csr_wdata = ebreak_q ? XLEN'(3) : XLEN'(11);
      end
      st_wr_mstatus: begin
        O_csr_we    = 1'b1;
        O_csr_waddr = csr_mstatus;
        O_csr_wdata = mstatus_q;
      end
      st_redirect: begin
        O_redirect_valid = 1'b1;
        O_redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

`ifdef TRAP_EBREAK_HALT_EN
  assign O_halt = (state_q == st_halt);
`else
  assign O_halt = 1'b0;
`endif

endmodule
